in256_out1536_pack: RTL
=======================

// Module: in256_out1536_pack
// PURPOSE
// - Width up-converter/packer: gathers narrow 256b AXI-Stream beats into full 1536b words.
// - Feeds the 1536b-wide buffers of the poly-systolic data route, e.g. systolic result
//   columns going back to DDR/DMA.
// - Beat payload width is run-time selectable: 64, 128 or 256 valid bits per beat.
// - Packed little-endian: first accepted lanes land in bits [63:0].
// PARAMETERS
// - IN_W   256   input beat width (bits)
// - OUT_W  1536  output word width (bits)
// - LANE_W 64    packing granule; OUT_W/LANE_W = 24 lanes per word
// PORTS
// - clk            in   1     single clock, all logic on posedge
// - rst            in   1     synchronous, active-high reset
// - pack_ctrl      in   3     one-hot beat size: 001=64b, 010=128b, 100=256b
// - s_axis_tdata   in   256   narrow input; only low 64/128/256 bits used per pack_ctrl
// - s_axis_tvalid  in   1     input valid
// - s_axis_tready  out  1     input ready
// - m_axis_tdata   out  1536  packed output word
// - m_axis_tvalid  out  1     output valid
// - m_axis_tready  in   1     output ready
// - s_axis_tlast / m_axis_tlast  in/out 1   only with PACK_TLAST_EN
// BEHAVIOUR
// - Reset (sync, rst=1): fill_cnt=0, asm_reg=0, out_reg=0, m_axis_tvalid=0, m_axis_tlast=0.
//   Any partial word is discarded, including one in progress mid-word.
// - Lane count k per beat: pack_ctrl[2] -> 4, else [1] -> 2, else 1.
//   Non-one-hot values resolve by this priority; 000 -> 64b.
// - Mode latch: pack_ctrl is sampled on the accepted beat with fill_cnt==0 and held for
//   that word. Changes mid-word are ignored until the next word.
// - s_axis_tready = (fill_cnt != 24). Combinational from state only; no input->output path.
// - Accept (tvalid & tready): asm_reg lanes [fill_cnt +: k] <= s_axis_tdata lanes [0 +: k];
//   fill_cnt += k.
//   - Beats per word: 24 (64b), 12 (128b), 6 (256b). No word straddles beats.
// - Completion: when fill_cnt reaches 24 (on the accept, or already stalled at 24):
//   - Output slot free (!m_axis_tvalid | m_axis_tready): in the same edge,
//     out_reg <= completed word, m_axis_tvalid <= 1, fill_cnt <= 0.
//   - Slot busy: fill_cnt holds 24, s_axis_tready=0; transfer on the first free-slot edge.
// - Latency: last input beat accepted at edge N -> m_axis_tvalid=1 after edge N when the
//   slot is free. Back-to-back words sustain one input beat per cycle while m_axis_tready=1.
// - Output: m_axis_tvalid drops on handshake unless a new word transfers in that same edge.
//   m_axis_tdata is stable while tvalid & !tready.
// CONFIGURATION
// - PACK_TLAST_EN defined:
//   - Accepted beat with s_axis_tlast=1 closes the word early.
//   - Unwritten lanes are zero-padded; the word is treated as complete (fill_cnt -> 24).
//   - m_axis_tlast=1 accompanies that word and is 0 on all others.
// - PACK_TLAST_EN undefined: tlast ports absent; words close only at 24 lanes.
// STRUCTURE
// - Shared package psys_route_pkg:
//   - LANE_W and lane-count localparams
//   - beat-mode typedef (MODE_64/128/256)
//   - function ctrl_to_lanes(pack_ctrl)
// - One sub-module: pack_lane_writer (combinational lane-enable/merge of a k-lane beat at
//   offset fill_cnt). Everything else lives in the top module.
// TESTING
// - 64b mode, 24 beats with lane0 = i (i=0..23), m_axis_tready=1:
//   one word, lane j == j; tvalid exactly one cycle after beat 23.
// - 256b mode, 12 back-to-back beats: two words emitted, s_axis_tready never drops,
//   lanes in accept order.
// - Backpressure, 128b mode, m_axis_tready=0: word1 held stable. 12 more beats take
//   fill_cnt to 24 and s_axis_tready=0. Raise m_axis_tready -> word1 then word2 emitted,
//   s_axis_tready returns to 1.
// - pack_ctrl toggled 001->100 after beat 5 of a 64b word: word still needs 24 single-lane
//   beats. The next word uses 256b mode.
// - rst asserted after 7 beats: outputs cleared next edge; following 24 beats give a clean
//   word with no stale lanes.
// - PACK_TLAST_EN, 128b mode: tlast on beat 3 -> word lanes 0..5 valid, 6..23 zero,
//   m_axis_tlast=1.

Source files
------------

// File: rtl/psys_route_pkg.sv
// Shared definitions for the poly-systolic data route: lane geometry, beat modes and
// the pack_ctrl decode used by the 256b->1536b packer.
package psys_route_pkg;

    localparam int IN_W      = 256;
    localparam int OUT_W     = 1536;
    localparam int LANE_W    = 64;
    localparam int IN_LANES  = IN_W / LANE_W;
    localparam int OUT_LANES = OUT_W / LANE_W;
    localparam int CNT_W     = 5;
    localparam int K_W       = 3;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_LANES);

    typedef enum logic [1:0] {
        MODE_64  = 2'd0,
        MODE_128 = 2'd1,
        MODE_256 = 2'd2
    } beat_mode_t;

    // Non-one-hot encodings resolve by priority: widest set bit wins, 000 means 64b.
    function automatic beat_mode_t ctrl_to_mode(input logic [2:0] ctrl);
        if (ctrl[2]) return MODE_256;
        if (ctrl[1]) return MODE_128;
        return MODE_64;
    endfunction

    function automatic logic [K_W-1:0] ctrl_to_lanes(input logic [2:0] ctrl);
        case (ctrl_to_mode(ctrl))
            MODE_256: return K_W'(4);
            MODE_128: return K_W'(2);
            default:  return K_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/pack_lane_writer.sv
// Combinational merge of a k-lane input beat into the assembly word at lane offset
// 'offset'; lanes outside [offset, offset+k) pass through unchanged.
module pack_lane_writer
    import psys_route_pkg::*;
(
    input  logic [OUT_W-1:0] asm_in,
    input  logic [IN_W-1:0]  beat,
    input  logic [CNT_W-1:0] offset,
    input  logic [K_W-1:0]   lanes,
    input  logic             wr_en,
    output logic [OUT_W-1:0] asm_out
);

    logic [CNT_W:0] lo;
    logic [CNT_W:0] hi;

    assign lo = {1'b0, offset};
    assign hi = lo + {{(CNT_W + 1 - K_W){1'b0}}, lanes};

    for (genvar i = 0; i < OUT_LANES; i++) begin : g_lane
        localparam logic [CNT_W:0] IDX = (CNT_W + 1)'(i);
        logic [1:0] sel;
        logic       hit;

        // A hit lane is at most k-1 <= 3 lanes past the offset, so two bits pick the source.
        assign sel = 2'(IDX - lo);
        assign hit = wr_en && (IDX >= lo) && (IDX < hi);
        assign asm_out[i*LANE_W +: LANE_W] =
            hit ? beat[int'(sel)*LANE_W +: LANE_W] : asm_in[i*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/in256_out1536_pack.sv
// 256b AXI-Stream to 1536b packer with run-time 64/128/256b beat payloads.
// Optional early word close on s_axis_tlast when PACK_TLAST_EN is defined.
module in256_out1536_pack
    import psys_route_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        pack_ctrl,
    input  logic [IN_W-1:0]   s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
`ifdef PACK_TLAST_EN
    input  logic              s_axis_tlast,
    output logic              m_axis_tlast,
`endif
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
);

    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] fill_sum;
    logic [K_W-1:0]   lanes_q;
    logic [K_W-1:0]   lanes_cur;
    logic [OUT_W-1:0] asm_reg;
    logic [OUT_W-1:0] asm_next;
    logic [OUT_W-1:0] out_reg;
    logic             accept;
    logic             close_early;
    logic             word_done;
    logic             slot_free;
    logic             xfer;
    logic             pop;

    assign s_axis_tready = (fill_cnt != FULL_CNT);
    assign accept        = s_axis_tvalid & s_axis_tready;

    // The beat size is taken live on the first beat of a word, then held for the rest.
    assign lanes_cur = (fill_cnt == '0) ? ctrl_to_lanes(pack_ctrl) : lanes_q;
    assign fill_sum  = fill_cnt + CNT_W'(lanes_cur);

`ifdef PACK_TLAST_EN
    assign close_early = accept & s_axis_tlast;
`else
    assign close_early = 1'b0;
`endif

    assign word_done = (fill_cnt == FULL_CNT) || (accept && (fill_sum == FULL_CNT)) || close_early;
    assign slot_free = ~m_axis_tvalid | m_axis_tready;
    assign xfer      = word_done & slot_free;
    assign pop       = m_axis_tvalid & m_axis_tready;

    pack_lane_writer u_writer (
        .asm_in  (asm_reg),
        .beat    (s_axis_tdata),
        .offset  (fill_cnt),
        .lanes   (lanes_cur),
        .wr_en   (accept),
        .asm_out (asm_next)
    );

    assign m_axis_tdata = out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt      <= '0;
            lanes_q       <= K_W'(1);
            // NOTE: asm_reg is cleared on reset and on every transfer; zero padding of an
            // early-closed word relies on unwritten lanes already being zero.
            asm_reg       <= '0;
            out_reg       <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (accept && (fill_cnt == '0)) lanes_q <= lanes_cur;
            if (xfer) begin
                out_reg       <= asm_next;
                m_axis_tvalid <= 1'b1;
                fill_cnt      <= '0;
                asm_reg       <= '0;
            end else begin
                if (pop) m_axis_tvalid <= 1'b0;
                asm_reg <= asm_next;
                if (word_done)   fill_cnt <= FULL_CNT;
                else if (accept) fill_cnt <= fill_sum;
            end
        end
    end

`ifdef PACK_TLAST_EN
    logic tlast_pend;

    // An early close that finds the slot busy parks its tlast until the word moves out.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tlast <= 1'b0;
            tlast_pend   <= 1'b0;
        end else if (xfer) begin
            m_axis_tlast <= tlast_pend | close_early;
            tlast_pend   <= 1'b0;
        end else begin
            if (pop)         m_axis_tlast <= 1'b0;
            if (close_early) tlast_pend   <= 1'b1;
        end
    end
`endif

endmodule
